ipv4_vlg_tx_arb: RTL and testbench
==================================

Name: ipv4_vlg_tx_arb

Overview:
- Packet-level arbiter directly downstream of the ICMP transmitter (and its sibling UDP/TCP transmitters) and upstream of the IPv4 TX serializer.
- Collects up to N_SRC pending IPv4 payload streams, each with header metadata.
- Grants one source at a time using round-robin, and holds the grant until that packet's last byte.
- Presents one flat stream, header fields included, to the IPv4 TX stage.

Parameters:
N_SRC, 3, number of upstream protocol transmitters (index 0 = ICMP)
TIMEOUT_TICKS, 65535, watchdog limit in clk cycles (only with IPV4_TX_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
src_rdy  input  N_SRC  source i has a packet pending; its header fields are stable while set
src_proto  input  N_SRC*8  IPv4 protocol field per source
src_dst_ip  input  N_SRC*32  destination IP per source
src_len  input  N_SRC*16  payload length in bytes per source
src_val  input  N_SRC  payload byte valid per source
src_dat  input  N_SRC*8  payload byte per source
src_eof  input  N_SRC  last payload byte per source
src_req  output  N_SRC  one-hot grant / data request to source
src_done  output  N_SRC  one-cycle pulse: packet of source i fully forwarded
out_rdy  output  1  header valid, packet pending to IPv4 TX
out_proto  output  8  muxed protocol
out_dst_ip  output  32  muxed destination IP
out_len  output  16  muxed payload length
out_req  input  1  IPv4 TX requests payload
out_val  output  1  payload byte valid
out_dat  output  8  payload byte
out_eof  output  1  last payload byte
out_err  output  1  one-cycle pulse: packet aborted

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; round-robin pointer = 0.
- FSM states: IDLE -> GRANT -> STREAM -> DONE -> IDLE.
- IDLE:
  - Scan src_rdy starting at pointer, wrapping modulo N_SRC.
  - The first set bit becomes sel; register sel and go to GRANT on the next edge.
  - If no src_rdy bit is set, stay in IDLE.
- GRANT:
  - Register out_proto, out_dst_ip and out_len from source sel, and assert out_rdy.
  - Header outputs are frozen until DONE.
  - Wait for out_req=1, then assert src_req[sel] on the following cycle and enter STREAM.
- STREAM:
  - out_val, out_dat and out_eof are src_* of sel, registered with 1-cycle latency.
  - Other sources' src_val is ignored.
  - Count forwarded bytes (16-bit).
  - On src_eof[sel] with src_val[sel]: deassert src_req and out_rdy, then go to DONE.
- DONE:
  - Pulse src_done[sel] for 1 cycle.
  - Pointer becomes sel+1, wrapping to 0 after N_SRC-1.
  - Return to IDLE; the next arbitration starts the cycle after.
- Length mismatch:
  - eof arrives while count+1 ≠ src_len: forward eof anyway, pulse out_err together with src_done.
  - count reaches src_len without eof: force out_eof on that byte, drop the grant, pulse out_err.
- src_rdy[sel] falling during GRANT: drop out_rdy, return to IDLE, no done or err pulse.
- src_rdy[sel] falling during STREAM: ignored.
- Arrival order is irrelevant; simultaneous requests are served round-robin, so every requesting source is served within N_SRC packets.
- src_len=0:
  - Packet is granted and the header is presented.
  - After out_req, go straight to DONE without a src_req pulse; no out_val is emitted.
- out_req deasserting mid-STREAM has no effect; IPv4 TX must hold out_req for the whole packet.
- Reset asserted mid-packet: immediate return to reset values; no err pulse.

Optional Feature:
- Macro: IPV4_TX_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles in GRANT/STREAM without progress (no out_req in GRANT, no src_val in STREAM).
  - Progress clears the counter.
  - At TIMEOUT_TICKS: emit out_eof with out_val=1, dat=0x00; pulse out_err and src_done[sel]; advance the pointer; go to IDLE.
- Undefined: no watchdog logic; a stalled source or sink holds the grant indefinitely.

Test Plan:
- Single ICMP packet: src_rdy=001, len=8, proto=0x01, dst=0xC0A80001 -> out_rdy with those fields; after out_req, 8 out_val bytes matching input at 1-cycle latency; out_eof on byte 8; src_done[0] pulse; out_err=0.
- Contention: src_rdy=111 held, each len=4 -> grants in order 0,1,2,0; no bytes from non-selected sources appear on out_dat.
- Short packet: len=10, eof on byte 6 -> 6 bytes out, out_eof on byte 6, out_err pulse and src_done in the same cycle.
- Zero length: len=0 on source 1 -> out_rdy, out_req, DONE; src_done[1] pulse; zero out_val; pointer = 2.
- Async reset during STREAM after byte 3 of 8 -> all outputs 0 immediately; next packet from pointer 0 forwards cleanly.
- With IPV4_TX_ARB_TIMEOUT_EN, TIMEOUT_TICKS=100, source stalls mid-STREAM -> after 100 idle cycles, out_eof+out_val with dat 0x00, out_err pulse, and the next source is granted.

Source files
------------

// File: rtl/ipv4_vlg_tx_arb.sv
// ipv4_vlg_tx_arb: round-robin packet arbiter feeding the IPv4 TX serializer.
// Optional watchdog enabled by defining IPV4_TX_ARB_TIMEOUT_EN. Rev 1.0
`default_nettype none

module ipv4_vlg_tx_arb #(
  parameter int N_SRC         = 3,
  parameter int TIMEOUT_TICKS = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    src_rdy,
  input  logic [N_SRC*8-1:0]  src_proto,
  input  logic [N_SRC*32-1:0] src_dst_ip,
  input  logic [N_SRC*16-1:0] src_len,
  input  logic [N_SRC-1:0]    src_val,
  input  logic [N_SRC*8-1:0]  src_dat,
  input  logic [N_SRC-1:0]    src_eof,
  output logic [N_SRC-1:0]    src_req,
  output logic [N_SRC-1:0]    src_done,
  output logic                out_rdy,
  output logic [7:0]          out_proto,
  output logic [31:0]         out_dst_ip,
  output logic [15:0]         out_len,
  input  logic                out_req,
  output logic                out_val,
  output logic [7:0]          out_dat,
  output logic                out_eof,
  output logic                out_err
);

  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [SEL_W:0]   N_SRC_W  = (SEL_W+1)'(N_SRC);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_SRC - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] scan_sel;
  logic [SEL_W:0]   scan_sum;
  logic             scan_hit;
  logic [N_SRC-1:0] sel_oh;
  logic             sel_rdy;
  logic             sel_val;
  logic             sel_eof;
  logic [7:0]       sel_dat;
  logic [15:0]      cnt;
  logic [15:0]      cnt_inc;
  logic             len_hit;
  logic             end_pkt;
  logic             err_flag;
  logic             timeout;

  assign sel_oh  = N_SRC'(1) << sel;
  assign sel_rdy = src_rdy[sel];
  assign sel_val = src_val[sel];
  assign sel_eof = src_eof[sel];
  assign sel_dat = src_dat[sel*8 +: 8];
  assign cnt_inc = cnt + 16'd1;
  assign len_hit = (cnt_inc == out_len);
  // A packet ends on the source's eof or when the advertised length is reached.
  assign end_pkt = sel_val && (sel_eof || len_hit);

  // Scan downwards so the source closest to ptr is the last (winning) assignment.
  always_comb begin
    scan_hit = 1'b0;
    scan_sel = '0;
    scan_sum = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      scan_sum = {1'b0, ptr} + (SEL_W+1)'(i);
      if (scan_sum >= N_SRC_W) scan_sum = scan_sum - N_SRC_W;
      if (src_rdy[scan_sum[SEL_W-1:0]]) begin
        scan_hit = 1'b1;
        scan_sel = scan_sum[SEL_W-1:0];
      end
    end
  end

`ifdef IPV4_TX_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_TICKS - 1);
  logic [15:0] wd_cnt;
  logic        stall;

  assign stall   = ((state == ST_GRANT) && !out_req) || ((state == ST_STREAM) && !sel_val);
  assign timeout = stall && (wd_cnt == WD_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_cnt <= 16'd0;
    else      wd_cnt <= stall ? wd_cnt + 16'd1 : 16'd0;
  end
`else
  // Watchdog compiled out; folds to a constant 0.
  assign timeout = (TIMEOUT_TICKS < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (scan_hit) state_nxt = ST_GRANT;
      ST_GRANT: begin
        if (!sel_rdy)     state_nxt = ST_IDLE;
        else if (timeout) state_nxt = ST_DONE;
        else if (out_req) state_nxt = (out_len == 16'd0) ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: if (end_pkt || timeout) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_rdy  = 1'b0;
    src_req  = '0;
    src_done = '0;
    out_err  = 1'b0;
    case (state)
      ST_GRANT:  out_rdy = 1'b1;
      ST_STREAM: begin
        out_rdy = 1'b1;
        src_req = sel_oh;
      end
      ST_DONE: begin
        src_done = sel_oh;
        out_err  = err_flag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel        <= '0;
      ptr        <= '0;
      cnt        <= 16'd0;
      err_flag   <= 1'b0;
      out_proto  <= 8'h00;
      out_dst_ip <= 32'h0;
      out_len    <= 16'd0;
      out_val    <= 1'b0;
      out_dat    <= 8'h00;
      out_eof    <= 1'b0;
    end else begin
      out_val <= 1'b0;
      out_dat <= 8'h00;
      out_eof <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (scan_hit) begin
            sel        <= scan_sel;
            out_proto  <= src_proto[scan_sel*8 +: 8];
            out_dst_ip <= src_dst_ip[scan_sel*32 +: 32];
            out_len    <= src_len[scan_sel*16 +: 16];
            cnt        <= 16'd0;
            err_flag   <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (sel_rdy && timeout) begin
            out_val  <= 1'b1;
            out_eof  <= 1'b1;
            err_flag <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (timeout) begin
            out_val  <= 1'b1;
            out_eof  <= 1'b1;
            err_flag <= 1'b1;
          end else begin
            out_val <= sel_val;
            out_dat <= sel_val ? sel_dat : 8'h00;
            out_eof <= end_pkt;
            if (sel_val) cnt <= cnt_inc;
            if (end_pkt) err_flag <= !(sel_eof && len_hit);
          end
        end
        ST_DONE: ptr <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ipv4_vlg_tx_arb.sv
// tb_ipv4_vlg_tx_arb: directed scoreboard bench for ipv4_vlg_tx_arb.
`default_nettype none

module tb_ipv4_vlg_tx_arb;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  src_rdy, src_val, src_eof, src_req, src_done;
  logic [N*8-1:0]  src_proto, src_dat;
  logic [N*32-1:0] src_dst_ip;
  logic [N*16-1:0] src_len;
  logic        out_rdy, out_req, out_val, out_eof, out_err;
  logic [7:0]  out_proto, out_dat;
  logic [31:0] out_dst_ip;
  logic [15:0] out_len;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_proto [N];
  logic [31:0] m_dst   [N];
  logic [15:0] m_len   [N];

  typedef struct packed {
    logic [7:0]   dat;
    logic         eof;
    logic [N-1:0] done;
    logic         err;
  } exp_t;
  exp_t q[$];

  ipv4_vlg_tx_arb #(.N_SRC(N), .TIMEOUT_TICKS(100)) dut (
    .clk(clk), .rst(rst),
    .src_rdy(src_rdy), .src_proto(src_proto), .src_dst_ip(src_dst_ip), .src_len(src_len),
    .src_val(src_val), .src_dat(src_dat), .src_eof(src_eof),
    .src_req(src_req), .src_done(src_done),
    .out_rdy(out_rdy), .out_proto(out_proto), .out_dst_ip(out_dst_ip), .out_len(out_len),
    .out_req(out_req), .out_val(out_val), .out_dat(out_dat), .out_eof(out_eof), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // Output monitor: every payload byte must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (out_val === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_byte: observed dat=%0h eof=%0b, required no output", out_dat, out_eof);
      end else begin
        exp_t e;
        e = q.pop_front();
        assert ({out_dat, out_eof, src_done, out_err} === e) else begin
          errors++;
          $error("FAIL byte: observed dat=%0h eof=%0b done=%b err=%0b, required dat=%0h eof=%0b done=%b err=%0b",
                 out_dat, out_eof, src_done, out_err, e.dat, e.eof, e.done, e.err);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int s, input logic [7:0] p, input logic [31:0] d, input logic [15:0] l);
    m_proto[s] = p;
    m_dst[s]   = d;
    m_len[s]   = l;
    src_proto[s*8 +: 8]   = p;
    src_dst_ip[s*32 +: 32] = d;
    src_len[s*16 +: 16]   = l;
  endtask

  // Non-selected sources chatter with valid/eof to prove they are ignored.
  task automatic drive_byte(input int s, input logic [7:0] d, input logic e);
    src_val = '1;
    src_eof = '1;
    src_dat = {N{8'hEE}};
    src_dat[s*8 +: 8] = d;
    src_eof[s] = e;
  endtask

  task automatic idle_src();
    src_val = '0;
    src_eof = '0;
    src_dat = '0;
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (out_rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, out_rdy, 1);
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, q.size(), 0);
  endtask

  task automatic start_pkt(input int s);
    logic [N-1:0] oh;
    int n = 0;
    oh = '0;
    oh[s] = 1'b1;
    wait_rdy($sformatf("grant_rdy_s%0d", s));
    chk("hdr_proto", out_proto, m_proto[s]);
    chk("hdr_dst_ip", out_dst_ip, m_dst[s]);
    chk("hdr_len", out_len, m_len[s]);
    chk("req_before_out_req", src_req, 0);
    out_req = 1'b1;
    while (src_req === '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("grant_req_s%0d", s), src_req, oh);
  endtask

  task automatic run_pkt(input int s, input int nbytes, input bit send_eof, input logic [7:0] seed);
    int nexp;
    bit err;
    bit last;
    exp_t e;
    logic [N-1:0] oh;
    oh = '0;
    oh[s] = 1'b1;
    nexp = (send_eof && nbytes <= int'(m_len[s])) ? nbytes : int'(m_len[s]);
    err  = !(send_eof && nbytes == int'(m_len[s]));
    start_pkt(s);
    for (int k = 0; k < nexp; k++) begin
      last = (k == nexp - 1);
      chk("stream_req", src_req, oh);
      drive_byte(s, seed + 8'(k), send_eof && (k == nbytes - 1));
      e.dat  = seed + 8'(k);
      e.eof  = last;
      e.done = last ? oh : '0;
      e.err  = last & err;
      q.push_back(e);
      @(negedge clk);
    end
    idle_src();
    out_req = 1'b0;
    chk("req_after_eof", src_req, 0);
    chk("rdy_after_eof", out_rdy, 0);
    drain("drain", 10);
  endtask

  initial begin
    exp_t e;
    src_rdy = '0; src_proto = '0; src_dst_ip = '0; src_len = '0;
    out_req = 1'b0;
    idle_src();
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {out_rdy, out_val, out_eof, out_err, src_req, src_done, out_dat}, 0);
    chk("reset_hdr", {out_proto, out_dst_ip, out_len}, 0);
    rst = 1'b1;

    // Single ICMP packet
    set_src(0, 8'h01, 32'hC0A80001, 16'd8);
    src_rdy = 3'b001;
    run_pkt(0, 8, 1'b1, 8'h10);
    src_rdy = '0;

    // Async reset after byte 3 of 8
    set_src(0, 8'h01, 32'hC0A80002, 16'd8);
    src_rdy = 3'b001;
    start_pkt(0);
    for (int k = 0; k < 3; k++) begin
      drive_byte(0, 8'hA0 + 8'(k), 1'b0);
      e.dat = 8'hA0 + 8'(k); e.eof = 1'b0; e.done = '0; e.err = 1'b0;
      q.push_back(e);
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    chk("midreset_ctrl", {out_rdy, out_val, out_eof, out_err, src_req, src_done, out_dat}, 0);
    chk("midreset_hdr", {out_proto, out_dst_ip, out_len}, 0);
    chk("midreset_queue", q.size(), 0);
    idle_src();
    src_rdy = '0;
    out_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Contention from pointer 0: order 0,1,2,0
    set_src(0, 8'h01, 32'h0A000010, 16'd4);
    set_src(1, 8'h11, 32'h0A000011, 16'd4);
    set_src(2, 8'h06, 32'h0A000012, 16'd4);
    src_rdy = '1;
    run_pkt(0, 4, 1'b1, 8'h20);
    run_pkt(1, 4, 1'b1, 8'h30);
    run_pkt(2, 4, 1'b1, 8'h40);
    run_pkt(0, 4, 1'b1, 8'h50);
    src_rdy = '0;

    // Zero-length packet on source 1
    set_src(1, 8'h11, 32'h0A000021, 16'd0);
    src_rdy = 3'b010;
    wait_rdy("zero_rdy");
    chk("zero_hdr_len", out_len, 0);
    chk("zero_hdr_dst", out_dst_ip, 32'h0A000021);
    out_req = 1'b1;
    @(negedge clk);
    chk("zero_done", src_done, 3'b010);
    chk("zero_err", out_err, 0);
    chk("zero_req", src_req, 0);
    chk("zero_val", out_val, 0);
    out_req = 1'b0;
    src_rdy = '0;
    @(negedge clk);
    chk("zero_done_pulse", src_done, 0);

    // Pointer now 2: short packet (eof on byte 6 of 10)
    set_src(2, 8'h06, 32'h0A000032, 16'd10);
    set_src(1, 8'h11, 32'h0A000031, 16'd4);
    set_src(0, 8'h01, 32'h0A000030, 16'd4);
    src_rdy = '1;
    run_pkt(2, 6, 1'b1, 8'h60);

    // Pointer wraps to 0: length reached without eof
    set_src(0, 8'h01, 32'h0A000040, 16'd3);
    run_pkt(0, 5, 1'b0, 8'h70);
    src_rdy = '0;

    // Source 1 withdraws during GRANT
    set_src(1, 8'h11, 32'h0A000051, 16'd8);
    src_rdy = 3'b010;
    wait_rdy("abort_rdy");
    chk("abort_hdr", out_dst_ip, 32'h0A000051);
    src_rdy = '0;
    @(negedge clk);
    chk("abort_out_rdy", out_rdy, 0);
    chk("abort_pulses", {src_done, out_err, src_req}, 0);
    @(negedge clk);
    chk("abort_no_done", src_done, 0);

    // Pointer still 1 after abort
    set_src(0, 8'h01, 32'h0A000060, 16'd4);
    src_rdy = 3'b011;
`ifdef IPV4_TX_ARB_TIMEOUT_EN
    start_pkt(1);
    for (int k = 0; k < 2; k++) begin
      drive_byte(1, 8'hB0 + 8'(k), 1'b0);
      e.dat = 8'hB0 + 8'(k); e.eof = 1'b0; e.done = '0; e.err = 1'b0;
      q.push_back(e);
      @(negedge clk);
    end
    idle_src();
    e.dat = 8'h00; e.eof = 1'b1; e.done = 3'b010; e.err = 1'b1;
    q.push_back(e);
    out_req = 1'b0;
    drain("timeout_drain", 150);
`else
    run_pkt(1, 8, 1'b1, 8'h80);
`endif
    run_pkt(0, 4, 1'b1, 8'h90);
    src_rdy = '0;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
